wb_mux_reg: RTL

- Registered N-way Wishbone B3 classic address decoder/mux: one master port fanned out to SLAVE_COUNT slave ports.
- Slave selected by per-port base/mask; all slave-side and master-side outputs registered for timing closure.
- Adds unmapped-address error termination, a slave-response watchdog timeout and master-abort handling.
- Sits between a bus master and a group of peripheral slaves in the interconnect layer.

---
 rtl/wb_mux_reg.sv | 139 +++++++++++++
 1 files changed

// File: rtl/wb_mux_reg.sv
// wb_mux_reg: registered Wishbone B3 classic 1-to-N address decoder/mux with
// unmapped-address error, slave-response watchdog and master-abort handling.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   wbm_*               master-side port (one request in flight at a time)
//   wbs_*_o / wbs_*_i   per-slave ports, slice i belongs to slave i
//   wbs_addr, _msk      per-slave base address and decode mask (quasi-static)
module wb_mux_reg #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int SLAVE_COUNT  = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_WIDTH-1:0]               wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]               wbm_dat_i,
    output logic [DATA_WIDTH-1:0]               wbm_dat_o,
    input  logic                                wbm_we_i,
    input  logic [SELECT_WIDTH-1:0]             wbm_sel_i,
    input  logic                                wbm_stb_i,
    input  logic                                wbm_cyc_i,
    output logic                                wbm_ack_o,
    output logic                                wbm_err_o,
    output logic                                wbm_rty_o,
    output logic [SLAVE_COUNT*ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [SLAVE_COUNT*DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [SLAVE_COUNT*DATA_WIDTH-1:0]   wbs_dat_o,
    output logic [SLAVE_COUNT-1:0]              wbs_we_o,
    output logic [SLAVE_COUNT*SELECT_WIDTH-1:0] wbs_sel_o,
    output logic [SLAVE_COUNT-1:0]              wbs_stb_o,
    output logic [SLAVE_COUNT-1:0]              wbs_cyc_o,
    input  logic [SLAVE_COUNT-1:0]              wbs_ack_i,
    input  logic [SLAVE_COUNT-1:0]              wbs_err_i,
    input  logic [SLAVE_COUNT-1:0]              wbs_rty_i,
    input  logic [SLAVE_COUNT*ADDR_WIDTH-1:0]   wbs_addr,
    input  logic [SLAVE_COUNT*ADDR_WIDTH-1:0]   wbs_addr_msk
);
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int IW = (SLAVE_COUNT > 1) ? $clog2(SLAVE_COUNT) : 1;

    typedef enum logic [1:0] {IDLE, ACTIVE, RESP} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          s_ack;
    logic          s_err;
    logic          s_rty;

    // Scan from the top down so the lowest matching slave is the last written.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = SLAVE_COUNT - 1; i >= 0; i--) begin
            if (((wbm_adr_i ^ wbs_addr[i*ADDR_WIDTH +: ADDR_WIDTH]) & wbs_addr_msk[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
            end
        end
    end

    assign s_ack = wbs_ack_i[idx_q];
    assign s_err = wbs_err_i[idx_q];
    assign s_rty = wbs_rty_i[idx_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wbm_dat_o <= '0;
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            wbs_adr_o <= '0;
            wbs_dat_o <= '0;
            wbs_we_o  <= '0;
            wbs_sel_o <= '0;
            wbs_stb_o <= '0;
            wbs_cyc_o <= '0;
        end else begin
            // Terminations are single-cycle pulses unless re-armed below.
            wbm_ack_o <= 1'b0;
            wbm_err_o <= 1'b0;
            wbm_rty_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wbm_cyc_i && wbm_stb_i) begin
                        if (hit) begin
                            // Data lines fan out to every slave; only stb/cyc select one.
                            wbs_adr_o <= {SLAVE_COUNT{wbm_adr_i}};
                            wbs_dat_o <= {SLAVE_COUNT{wbm_dat_i}};
                            wbs_we_o  <= {SLAVE_COUNT{wbm_we_i}};
                            wbs_sel_o <= {SLAVE_COUNT{wbm_sel_i}};
                            wbs_stb_o <= SLAVE_COUNT'(1) << hit_idx;
                            wbs_cyc_o <= SLAVE_COUNT'(1) << hit_idx;
                            idx_q     <= hit_idx;
                            cnt_q     <= '0;
                            state_q   <= ACTIVE;
                        end else begin
                            wbm_err_o <= 1'b1;
                            state_q   <= RESP;
                        end
                    end
                end
                ACTIVE: begin
                    if (!wbm_cyc_i) begin
                        // Master abort: any response arriving now is dropped.
                        wbs_stb_o <= '0;
                        wbs_cyc_o <= '0;
                        state_q   <= IDLE;
                    end else if (s_ack || s_err || s_rty) begin
                        wbm_err_o <= s_err;
                        wbm_rty_o <= !s_err && s_rty;
                        wbm_ack_o <= !s_err && !s_rty;
                        if (!s_err && !s_rty)
                            wbm_dat_o <= wbs_dat_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
                        wbs_stb_o <= '0;
                        wbs_cyc_o <= '0;
                        state_q   <= RESP;
                    end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1)) begin
                        wbm_err_o <= 1'b1;
                        wbs_stb_o <= '0;
                        wbs_cyc_o <= '0;
                        state_q   <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
